load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage load/store unit between the pipeline's execute/memory boundary and `data_cache`. Accepts one load or store per handshake, converts byte/halfword/word accesses into word-aligned cache requests, and performs read-modify-write for sub-word stores because the cache accepts full-word stores only. Extracts and sign/zero-extends load data, and returns a single-cycle completion pulse to writeback.

## Interface
Parameters:
- `ADDR_SIZE`, 32, address width
- `DATA_SIZE`, 32, data/word width; fixed at 32 by byte-lane logic

Ports:
- `i_aclk` in 1: system clock
- `i_areset` in 1: reset. **Synchronous, active-high.**
- `i_valid` in 1: pipeline op valid
- `o_ready` out 1: unit idle, op accepted when `i_valid && o_ready`
- `i_store` in 1: 1 = store, 0 = load
- `i_funct3` in 3: RV32 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `i_addr` in ADDR_SIZE: byte address
- `i_wdata` in DATA_SIZE: store data, right-justified
- `i_rd` in 5: destination register tag
- `o_valid` out 1: completion pulse, 1 cycle
- `o_rdata` out DATA_SIZE: extended load data; 0 for stores
- `o_rd` out 5: tag of completed op
- `o_misaligned` out 1: misaligned exception, qualified by `o_valid`
- `o_req` out 1: to cache `i_req`
- `o_req_write` out 1: to cache `i_req_write`
- `o_addr` out ADDR_SIZE: to cache `i_addr`, always `{addr[ADDR_SIZE-1:2],2'b00}`
- `o_store_data` out DATA_SIZE: to cache `i_store_data`
- `i_req_ready` in 1: cache `o_req_ready`
- `i_data_valid` in 1: cache `o_data_valid`
- `i_data` in DATA_SIZE: cache `o_data`

## Operation
- Op latched on accept: address, store flag, funct3, wdata, rd.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE.
- IDLE: `o_ready`=1. On accept: load or sub-word store → RD_REQ; word store → WR_REQ; misaligned with macro enabled → DONE.
- RD_REQ: `o_req`=1, `o_req_write`=0; on `i_req_ready` → RD_WAIT, `o_req` drops next cycle.
- RD_WAIT: on `i_data_valid` capture `i_data`; load → DONE; sub-word store → WR_REQ with merged word.
- WR_REQ: `o_req`=1, `o_req_write`=1, `o_store_data` = merged word (SW: `i_wdata`; SB: byte lane `addr[1:0]` replaced by `wdata[7:0]`; SH: halfword lane `addr[1]` replaced by `wdata[15:0]`). On `i_req_ready` → WR_WAIT.
- WR_WAIT: on `i_data_valid` → DONE.
- DONE: `o_valid`=1 one cycle → IDLE.
- Load extract: byte lane `addr[1:0]`, halfword lane `addr[1]`; funct3 000/001 sign-extend, 100/101 zero-extend, 010 whole word.
- Reserved funct3 (011, 110, 111): treated as word access.
- `o_req` and payload held stable from assertion until `i_req_ready` sampled high.
- `i_data_valid` outside RD_WAIT/WR_WAIT ignored.

## Timing
- Reset: state IDLE; `o_ready`=1 after reset deasserts, 0 while asserted; `o_valid`, `o_req`, `o_req_write`, `o_misaligned`=0; `o_addr`, `o_store_data`, `o_rdata`, `o_rd`=0.
- Reset mid-operation: returns to IDLE next edge, op discarded, no `o_valid`; cache is reset by same signal.
- Accept at edge N → `o_req` high in cycle N+1.
- Load: `o_valid` in the cycle after the edge sampling `i_data_valid`. Minimum latency (cache ready immediately, data_valid next cycle) = 4 cycles accept-to-`o_valid`.
- Word store: one cache transaction; sub-word store: two (read, then write); minimum 6 cycles.
- `o_ready` low from accept edge through DONE; high again in cycle after DONE. One op in flight max.
- Simultaneous `i_valid` and reset: reset wins, op not accepted.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: H/HU/SH with `addr[0]`=1, or W/SW with `addr[1:0]`≠0, issue no cache request; DONE reached one cycle after accept with `o_valid`=1, `o_misaligned`=1, `o_rdata`=0; no memory modified.
- Not defined: misaligned low address bits are ignored (halfword uses `addr[1]` lane only, word ignores `addr[1:0]`); `o_misaligned` tied 0.

## Test plan
- LW `addr=0x100`, cache returns `0xDEADBEEF` → `o_valid`, `o_rdata=0xDEADBEEF`, `o_addr=0x100`, `o_req_write`=0.
- LB `addr=0x103` then LBU same address, cache word `0x80FF_1234` → `o_rdata=0xFFFFFF80` then `0x00000080`.
- SB `addr=0x202`, `wdata=0xAB`, read returns `0x11223344` → second request `o_req_write`=1, `o_store_data=0x11AB3344`, exactly two cache requests.
- SW `addr=0x300`, `wdata=0xCAFEF00D`, `i_req_ready` held low 5 cycles → `o_req`/payload stable throughout, single write request, `o_rdata=0`.
- LH `addr=0x101`: with `LSU_MISALIGN_TRAP_EN`, no `o_req`, `o_valid` and `o_misaligned`=1 cycle after accept; without, read of `0x100`, lane `addr[1]`=0 returned.
- Reset asserted in RD_WAIT → next cycle `o_ready`=1, `o_req`=0, no `o_valid`; following LW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word loads and stores over a word-only data cache, sub-word stores via read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of ignoring the low address bits.
module load_store_unit #(
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32
) (
  input  logic                 i_aclk,
  input  logic                 i_areset,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_store,
  input  logic [2:0]           i_funct3,
  input  logic [ADDR_SIZE-1:0] i_addr,
  input  logic [DATA_SIZE-1:0] i_wdata,
  input  logic [4:0]           i_rd,
  output logic                 o_valid,
  output logic [DATA_SIZE-1:0] o_rdata,
  output logic [4:0]           o_rd,
  output logic                 o_misaligned,
  output logic                 o_req,
  output logic                 o_req_write,
  output logic [ADDR_SIZE-1:0] o_addr,
  output logic [DATA_SIZE-1:0] o_store_data,
  input  logic                 i_req_ready,
  input  logic                 i_data_valid,
  input  logic [DATA_SIZE-1:0] i_data
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE} state_t;
  state_t state;
  logic [1:0] lane;
  logic [2:0] funct3;
  logic store;
  logic [DATA_SIZE-1:0] wdata, mask, shifted, merged, loaded;
  logic [4:0] shamt;
  logic accept, misaligned, byte_op, half_op;
  assign o_ready = state == IDLE && !i_areset;
  assign accept = i_valid && o_ready;
`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = (i_funct3[1:0] == 2'b01 && i_addr[0]) || (i_funct3[1] && i_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif
  // Access size of the latched op; reserved encodings fall through to word.
  assign byte_op = funct3[1:0] == 2'b00;
  assign half_op = funct3[1:0] == 2'b01;
  assign shamt = byte_op ? {lane, 3'b000} : half_op ? {lane[1], 4'b0000} : 5'd0;
  assign mask = byte_op ? DATA_SIZE'(8'hFF) : half_op ? DATA_SIZE'(16'hFFFF) : '1;
  assign merged = (i_data & ~(mask << shamt)) | ((wdata & mask) << shamt);
  assign shifted = i_data >> shamt;
  assign loaded = byte_op ? {{24{shifted[7] & ~funct3[2]}}, shifted[7:0]}
                : half_op ? {{16{shifted[15] & ~funct3[2]}}, shifted[15:0]} : i_data;
  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      state <= IDLE;
      lane <= '0;
      funct3 <= '0;
      store <= 1'b0;
      wdata <= '0;
      o_valid <= 1'b0;
      o_rdata <= '0;
      o_rd <= '0;
      o_misaligned <= 1'b0;
      o_req <= 1'b0;
      o_req_write <= 1'b0;
      o_addr <= '0;
      o_store_data <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          lane <= i_addr[1:0];
          funct3 <= i_funct3;
          store <= i_store;
          wdata <= i_wdata;
          o_rd <= i_rd;
          o_addr <= {i_addr[ADDR_SIZE-1:2], 2'b00};
          if (misaligned) begin
            state <= DONE;
            o_valid <= 1'b1;
            o_misaligned <= 1'b1;
            o_rdata <= '0;
          end else if (i_store && i_funct3[1]) begin
            state <= WR_REQ;
            o_req <= 1'b1;
            o_req_write <= 1'b1;
            o_store_data <= i_wdata;
          end else begin
            state <= RD_REQ;
            o_req <= 1'b1;
            o_req_write <= 1'b0;
          end
        end
        RD_REQ: if (i_req_ready) begin
          state <= RD_WAIT;
          o_req <= 1'b0;
        end
        RD_WAIT: if (i_data_valid) begin
          if (store) begin
            state <= WR_REQ;
            o_req <= 1'b1;
            o_req_write <= 1'b1;
            o_store_data <= merged;
          end else begin
            state <= DONE;
            o_valid <= 1'b1;
            o_misaligned <= 1'b0;
            o_rdata <= loaded;
          end
        end
        WR_REQ: if (i_req_ready) begin
          state <= WR_WAIT;
          o_req <= 1'b0;
        end
        WR_WAIT: if (i_data_valid) begin
          state <= DONE;
          o_valid <= 1'b1;
          o_misaligned <= 1'b0;
          o_rdata <= '0;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors against a byte-level memory/load model, with a responding cache model.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_valid = 1'b0, i_store = 1'b0;
  logic [2:0] i_funct3 = '0;
  logic [31:0] i_addr = '0, i_wdata = '0;
  logic [4:0] i_rd = '0;
  logic o_ready, o_valid, o_misaligned, o_req, o_req_write;
  logic [31:0] o_rdata, o_addr, o_store_data;
  logic [4:0] o_rd;
  logic i_req_ready, i_data_valid;
  logic [31:0] i_data;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  typedef struct {logic [4:0] rd; logic [31:0] rdata; logic mis;} exp_t;
  typedef struct {logic st; logic [2:0] f3; logic [31:0] addr; logic [31:0] wdata; int stall; logic [31:0] val; int lat; int nreq;} vec_t;
  exp_t exp_q[$];
  vec_t vecs[13];
  logic [31:0] mem [logic [31:0]];
  int n_chk = 0, n_pass = 0, n_req = 0, n_wr = 0, stall = 0, wait_cnt = 0;
  logic [31:0] exp_addr = '0, cap_addr, cap_data, h_addr, h_data;
  logic cap_wr, hs, hold = 1'b0, h_wr;

  load_store_unit dut (
    .i_aclk(clk), .i_areset(rst), .i_valid(i_valid), .o_ready(o_ready), .i_store(i_store),
    .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata), .i_rd(i_rd), .o_valid(o_valid),
    .o_rdata(o_rdata), .o_rd(o_rd), .o_misaligned(o_misaligned), .o_req(o_req),
    .o_req_write(o_req_write), .o_addr(o_addr), .o_store_data(o_store_data),
    .i_req_ready(i_req_ready), .i_data_valid(i_data_valid), .i_data(i_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic is_mis(input logic [2:0] f3, input logic [31:0] a);
    return TRAP && (a % size_of(f3)) != 0;
  endfunction

  function automatic logic [31:0] load_ref(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f3);
    int s, base;
    longint v;
    s = size_of(f3);
    base = int'(a % 4) / s * s;
    v = longint'(w >> (8 * base)) & ((longint'(1) << (8 * s)) - 1);
    if (s < 4 && !f3[2] && v >= (longint'(1) << (8 * s - 1))) v = v - (longint'(1) << (8 * s));
    return v[31:0];
  endfunction

  function automatic logic [31:0] store_ref(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
    logic [7:0] b [4];
    int s, base;
    s = size_of(f3);
    base = int'(a % 4) / s * s;
    for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
    for (int i = 0; i < s; i++) b[base + i] = d[8*i +: 8];
    return {b[3], b[2], b[1], b[0]};
  endfunction

  // Cache model: grants after `stall` cycles of o_req, answers one cycle after the handshake.
  initial begin
    i_req_ready = 1'b0;
    i_data_valid = 1'b0;
    i_data = '0;
    hs = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      i_data_valid = 1'b0;
      if (rst) begin
        hs = 1'b0;
        i_req_ready = 1'b0;
        wait_cnt = 0;
      end else if (hs) begin
        hs = 1'b0;
        i_req_ready = 1'b0;
        n_req++;
        if (cap_wr) begin
          mem[cap_addr] = cap_data;
          n_wr++;
          i_data = '0;
        end else i_data = mem_rd(cap_addr);
        i_data_valid = 1'b1;
      end else if (o_req) begin
        if (wait_cnt >= stall) begin
          i_req_ready = 1'b1;
          hs = 1'b1;
          cap_addr = o_addr;
          cap_wr = o_req_write;
          cap_data = o_store_data;
          wait_cnt = 0;
        end else wait_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (hold) begin
        chk("req_held", o_req, 1);
        chk("addr_held", o_addr, h_addr);
        chk("data_held", o_store_data, h_data);
        chk("write_held", o_req_write, h_wr);
      end
      if (o_req) chk("req_addr", o_addr, exp_addr);
      if (o_valid) begin
        if (exp_q.size() == 0) chk("unexpected_valid", o_valid, 0);
        else begin
          chk("rdata", o_rdata, exp_q[0].rdata);
          chk("rd", o_rd, exp_q[0].rd);
          chk("misaligned", o_misaligned, exp_q[0].mis);
          void'(exp_q.pop_front());
        end
      end
    end
    hold <= !rst && o_req && !i_req_ready;
    h_addr <= o_addr;
    h_data <= o_store_data;
    h_wr <= o_req_write;
  end

  task automatic op(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                    input logic [4:0] rd, input int s, output int lat, output int nreq, output int nwr,
                    output logic [31:0] rdata);
    logic [31:0] pre, wa;
    int k;
    k = 0;
    while (!o_ready && k < 50) begin
      @(posedge clk);
      #2;
      k++;
    end
    chk("ready_wait", o_ready, 1);
    wa = {a[31:2], 2'b00};
    pre = mem_rd(wa);
    exp_q.push_back('{rd: rd, rdata: (st || is_mis(f3, a)) ? 32'h0 : load_ref(pre, a, f3), mis: is_mis(f3, a)});
    exp_addr = wa;
    stall = s;
    nreq = n_req;
    nwr = n_wr;
    i_valid = 1'b1;
    i_store = st;
    i_funct3 = f3;
    i_addr = a;
    i_wdata = d;
    i_rd = rd;
    @(posedge clk);
    #2;
    i_valid = 1'b0;
    lat = 0;
    rdata = 'x;
    for (int j = 1; j <= 200 && lat == 0; j++) begin
      @(negedge clk);
      if (o_valid) begin
        lat = j + 1;
        rdata = o_rdata;
      end
    end
    chk("completion_timeout", 32'(lat != 0), 1);
    nreq = n_req - nreq;
    nwr = n_wr - nwr;
    if (st) chk("mem_model", mem_rd(wa), is_mis(f3, a) ? pre : store_ref(pre, a, f3, d));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, nreq, nwr, r0;
    logic [31:0] rdata;
    vecs = '{
      '{1'b0, 3'b010, 32'h100, 32'h0,        0, 32'hDEADBEEF, 4,  1},
      '{1'b1, 3'b010, 32'h100, 32'h80FF1234, 0, 32'h80FF1234, 4,  1},
      '{1'b0, 3'b000, 32'h103, 32'h0,        0, 32'hFFFFFF80, 4,  1},
      '{1'b0, 3'b100, 32'h103, 32'h0,        0, 32'h00000080, 4,  1},
      '{1'b0, 3'b001, 32'h102, 32'h0,        1, 32'hFFFF80FF, 5,  1},
      '{1'b0, 3'b101, 32'h102, 32'h0,        0, 32'h000080FF, 4,  1},
      '{1'b1, 3'b000, 32'h202, 32'h000000AB, 0, 32'h11AB3344, 6,  2},
      '{1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 5, 32'hCAFEF00D, 9,  1},
      '{1'b1, 3'b001, 32'h206, 32'h1234BEEF, 0, 32'hBEEF0000, 6,  2},
      '{1'b0, 3'b011, 32'h204, 32'h0,        0, 32'hBEEF0000, 4,  1},
      '{1'b1, 3'b000, 32'h201, 32'h0000005A, 2, 32'h11AB5A44, 10, 2},
      '{1'b0, 3'b100, 32'h202, 32'h0,        3, 32'h000000AB, 7,  1},
      '{1'b0, 3'b000, 32'h201, 32'h0,        0, 32'h0000005A, 4,  1}
    };
    mem[32'h100] = 32'hDEADBEEF;
    mem[32'h200] = 32'h11223344;
    mem[32'h400] = 32'h13579BDF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", o_ready, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_req", o_req, 0);
    chk("rst_req_write", o_req_write, 0);
    chk("rst_misaligned", o_misaligned, 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_store_data", o_store_data, 0);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_rd", o_rd, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", o_ready, 1);
    foreach (vecs[i]) begin
      op(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata, 5'(i + 1), vecs[i].stall, lat, nreq, nwr, rdata);
      chk($sformatf("lat_%0d", i), lat, vecs[i].lat);
      chk($sformatf("nreq_%0d", i), nreq, vecs[i].nreq);
      chk($sformatf("nwr_%0d", i), nwr, {31'b0, vecs[i].st});
      if (vecs[i].st) begin
        chk($sformatf("mem_%0d", i), mem_rd({vecs[i].addr[31:2], 2'b00}), vecs[i].val);
        chk($sformatf("store_rdata_%0d", i), rdata, 0);
      end else chk($sformatf("load_%0d", i), rdata, vecs[i].val);
    end
    op(1'b0, 3'b001, 32'h101, 32'h0, 5'd20, 0, lat, nreq, nwr, rdata);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_lat", lat, 2);
    chk("mis_nreq", nreq, 0);
    chk("mis_rdata", rdata, 0);
`else
    chk("lh101_lat", lat, 4);
    chk("lh101_nreq", nreq, 1);
    chk("lh101_rdata", rdata, 32'h00001234);
`endif
    @(posedge clk);
    #2;
    exp_addr = 32'h400;
    stall = 0;
    i_valid = 1'b1;
    i_store = 1'b0;
    i_funct3 = 3'b010;
    i_addr = 32'h400;
    i_rd = 5'd21;
    @(posedge clk);
    #2;
    i_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", o_ready, 1);
    chk("midrst_req", o_req, 0);
    chk("midrst_valid", o_valid, 0);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_valid", o_valid, 0);
    end
    op(1'b0, 3'b010, 32'h400, 32'h0, 5'd22, 0, lat, nreq, nwr, rdata);
    chk("post_rst_lat", lat, 4);
    chk("post_rst_rdata", rdata, 32'h13579BDF);
    @(posedge clk);
    #2;
    r0 = n_req;
    rst = 1'b1;
    i_valid = 1'b1;
    i_addr = 32'h500;
    @(posedge clk);
    #2;
    rst = 1'b0;
    i_valid = 1'b0;
    @(negedge clk);
    chk("rstvalid_ready", o_ready, 1);
    chk("rstvalid_req", o_req, 0);
    repeat (3) @(negedge clk);
    chk("rstvalid_nreq", n_req - r0, 0);
    chk("pending_completions", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
